nc_inv_mon_mc: RTL and testbench
================================

# nc_inv_mon_mc

Multi-channel, parametrised monitor for non-cacheable loads that invalidate the I$, sitting on the CPX return path of the manycore verification environment. It watches NUM_CH CPX packet streams in parallel and flags any load return (rtntype LOAD) with both nc and wv set. For each violation it keeps per-channel saturating counters and a sticky error, and pushes a timestamped violation record into a small FIFO for the testbench to drain. Enable and fatal behaviour are controlled by runtime ports instead of plusargs. A post-reset grace window and a trip state machine are added.

## Interface
- NUM_CH, 8, number of monitored CPX channels (cores)
- CNT_W, 8, width of each per-channel violation counter
- CYC_W, 32, width of cycle stamp
- FIFO_DEPTH, 4, record FIFO depth (power of 2, >=2)
- GRACE_CYC, 16, cycles after reset release during which checks are ignored (0 = none)
- clk  in  1  sole clock; all logic posedge
- rst_l  in  1  asynchronous, active-low reset
- chk_en  in  1  detection enable; 0 = no detection, no state change from packets
- fatal_en  in  1  1 = first violation trips and pulses fatal; 0 = warn-only
- clr  in  1  synchronous clear of counters, err_sticky, ovf, trip state
- cpx_vld  in  NUM_CH  per-channel packet valid
- cpx_rtntype  in  4*NUM_CH  per-channel return type, channel i at [4i+3:4i]
- cpx_nc  in  NUM_CH  non-cacheable bit
- cpx_wv  in  NUM_CH  I$ way-valid (invalidate) bit
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_mask  out  NUM_CH  channels violating in the recorded cycle
- rec_cycle  out  CYC_W  cycle stamp of recorded violation
- viol_cnt  out  NUM_CH*CNT_W  per-channel counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]
- err_sticky  out  1  any violation since reset/clr
- fatal  out  1  one-cycle pulse on trip
- ovf  out  1  sticky: a record was dropped on a full FIFO

## Operation
- Violation on channel i: cpx_vld[i] & rtntype==4'b0000 & nc[i] & wv[i]. Qualified by chk_en and state!=GRACE. viol_mask is the NUM_CH-bit vector of violating channels.
- FSM states: GRACE (reset state; counts GRACE_CYC cycles, then ARMED; GRACE_CYC=0 makes the first cycle ARMED), ARMED, TRIPPED.
  - ARMED -> TRIPPED when viol_mask!=0 and fatal_en.
  - TRIPPED -> ARMED on clr.
  - In TRIPPED, counting and recording continue; fatal is not re-pulsed.
- Counters: +1 per cycle per violating channel; saturate at all-ones; no wrap.
- Record: one FIFO entry per cycle with viol_mask!=0, holding {viol_mask, cycle_cnt}. Simultaneous violations on several channels therefore produce one entry, not several.
- Cycle counter: 0 in the first cycle after reset release, +1 every cycle, wraps modulo 2^CYC_W, and is not cleared by clr.
- FIFO full with a push: the record is dropped and ovf is set. Full with simultaneous push and pop: both are accepted, no drop. Empty with a pop request: ignored.
- clr takes priority over same-cycle counter, err_sticky and ovf updates; these read 0 the next cycle. The FIFO is not flushed by clr, and a violation in the clr cycle is still recorded.
- Reset values: rec_valid 0, rec_mask 0, rec_cycle 0, viol_cnt 0, err_sticky 0, fatal 0, ovf 0, state GRACE, FIFO empty. Asserting reset mid-operation discards all FIFO contents immediately.

## Timing
- Violation sampled at edge t. Counters, err_sticky and the fatal pulse are visible after edge t (registered, 1-cycle latency).
- The record lands in the FIFO at edge t. With the FIFO previously empty, rec_valid=1 in the following cycle. No combinational path from cpx_* to rec_*.
- A pop occurs at an edge where rec_valid & rec_ready. rec_ready has no combinational effect on any output in the same cycle.
- The GRACE exit edge is the GRACE_CYC-th edge after reset release. Violations in the cycle following that edge are checked.

## Structure
- Package nc_inv_pkg: the RTN_LOAD=4'b0000 constant, the FSM state enum {GRACE, ARMED, TRIPPED}, and the record struct (mask, cycle) parametrised via localparams or typedef in the instantiating module.
- Sub-module nc_inv_rec_fifo: a synchronous FIFO with valid/ready output, full flag and async active-low reset. The top level holds detection, counters, FSM and cycle counter.

## Test plan
- GRACE_CYC=16: a violation on channel 2 at cycle 5 is ignored (cnt 0, no record). The same violation at cycle 20 gives cnt[2]=1, err_sticky=1, and rec_mask=0x04, rec_cycle=20 after one cycle.
- fatal_en=1: violations on channels 0 and 7 in the same cycle give one record with mask 0x81, fatal high for exactly 1 cycle, and state TRIPPED. A further violation increments counters without a second fatal. clr returns the FSM to ARMED.
- rec_ready=0 with 6 consecutive violating cycles and FIFO_DEPTH=4: 4 records are held and ovf=1. Draining returns cycles in order with no gaps among the first four.
- FIFO full with a violation and rec_ready=1 in the same cycle: no drop, ovf stays 0, occupancy stays 4.
- CNT_W=8 with 300 violations on channel 1: viol_cnt[1]=255. clr in a violating cycle gives cnt=0 next cycle, and that cycle's record is present.
- chk_en=0, or rtntype!=0, or nc=0, or wv=0: no counter, record or sticky change. Asserting rst_l low mid-drain clears all outputs immediately.

Source files
------------

// File: rtl/nc_inv_pkg.sv
// Shared constants and types for the non-cacheable I$-invalidate load monitor.
package nc_inv_pkg;

    localparam logic [3:0] RTN_LOAD = 4'b0000;

    typedef enum logic [1:0] {
        GRACE   = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } state_e;

endpackage

// File: rtl/nc_inv_rec_fifo.sv
// Violation record FIFO: valid/ready head, full flag, simultaneous push+pop when full.
module nc_inv_rec_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid = ~empty;
    // Drive zeros when empty so the head never exposes a stale record.
    assign data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/nc_inv_mon_mc.sv
// Multi-channel monitor flagging CPX load returns with nc and wv both set;
// per-channel saturating counters, sticky error, trip FSM and timestamped record FIFO.
module nc_inv_mon_mc
    import nc_inv_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CNT_W      = 8,
    parameter int CYC_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GRACE_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    chk_en,
    input  logic                    fatal_en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       cpx_vld,
    input  logic [4*NUM_CH-1:0]     cpx_rtntype,
    input  logic [NUM_CH-1:0]       cpx_nc,
    input  logic [NUM_CH-1:0]       cpx_wv,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [NUM_CH-1:0]       rec_mask,
    output logic [CYC_W-1:0]        rec_cycle,
    output logic [NUM_CH*CNT_W-1:0] viol_cnt,
    output logic                    err_sticky,
    output logic                    fatal,
    output logic                    ovf
);
    typedef struct packed {
        logic [NUM_CH-1:0] mask;
        logic [CYC_W-1:0]  cycle;
    } rec_t;

    localparam int GW = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;
    localparam logic [GW-1:0] GRACE_LAST = GW'((GRACE_CYC > 0) ? GRACE_CYC - 1 : 0);
    // With no grace window the monitor comes out of reset already armed.
    localparam state_e RST_STATE = (GRACE_CYC == 0) ? ARMED : GRACE;

    state_e                         state_q, state_d;
    logic [GW-1:0]                  grace_cnt_q, grace_cnt_d;
    logic [CYC_W-1:0]               cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                           err_q, err_d;
    logic                           fatal_q, fatal_d;
    logic                           ovf_q, ovf_d;

    logic [NUM_CH-1:0]              viol_mask;
    logic                           any_viol;
    logic                           fifo_full;
    logic                           fifo_pop;
    logic                           drop;
    rec_t                           push_rec;
    rec_t                           head_rec;

    always_comb begin
        viol_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            viol_mask[i] = cpx_vld[i] && (cpx_rtntype[4*i +: 4] == RTN_LOAD)
                           && cpx_nc[i] && cpx_wv[i];
        end
        if (!chk_en || state_q == GRACE) viol_mask = '0;
    end

    assign any_viol = |viol_mask;
    assign fifo_pop = rec_valid & rec_ready;
    assign drop     = any_viol & fifo_full & ~fifo_pop;

    always_comb begin
        state_d     = state_q;
        grace_cnt_d = grace_cnt_q;
        fatal_d     = 1'b0;
        unique case (state_q)
            GRACE: begin
                if (grace_cnt_q == GRACE_LAST) state_d = ARMED;
                else                           grace_cnt_d = grace_cnt_q + GW'(1);
            end
            ARMED: begin
                if (!clr && any_viol && fatal_en) begin
                    state_d = TRIPPED;
                    fatal_d = 1'b1;
                end
            end
            TRIPPED: begin
                if (clr) state_d = ARMED;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        err_d       = clr ? 1'b0 : (err_q | any_viol);
        ovf_d       = clr ? 1'b0 : (ovf_q | drop);
        cnt_d       = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr)                             cnt_d[i] = '0;
            else if (viol_mask[i] && ~&cnt_q[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= RST_STATE;
            grace_cnt_q <= '0;
            cycle_cnt_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            fatal_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grace_cnt_q <= grace_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fatal_q     <= fatal_d;
            ovf_q       <= ovf_d;
        end
    end

    assign push_rec.mask  = viol_mask;
    assign push_rec.cycle = cycle_cnt_q;

    nc_inv_rec_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (any_viol),
        .push_data (push_rec),
        .pop       (rec_ready),
        .valid     (rec_valid),
        .data      (head_rec),
        .full      (fifo_full)
    );

    assign rec_mask   = head_rec.mask;
    assign rec_cycle  = head_rec.cycle;
    assign viol_cnt   = cnt_q;
    assign err_sticky = err_q;
    assign fatal      = fatal_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_nc_inv_mon_mc.sv
// Directed bench for nc_inv_mon_mc: a queue/array reference model checked every cycle,
// plus hand-computed literal checks at the test-plan milestones.
module tb_nc_inv_mon_mc;
    localparam int NCH   = 8;
    localparam int DEPTH = 4;
    localparam int GRACE = 16;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        chk_en, fatal_en, clr, rec_ready;
    logic [7:0]  cpx_vld, cpx_nc, cpx_wv;
    logic [31:0] cpx_rtntype;
    logic        rec_valid, err_sticky, fatal, ovf;
    logic [7:0]  rec_mask;
    logic [31:0] rec_cycle;
    logic [63:0] viol_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    nc_inv_mon_mc #(
        .NUM_CH(NCH), .CNT_W(8), .CYC_W(32), .FIFO_DEPTH(DEPTH), .GRACE_CYC(GRACE)
    ) dut (
        .clk(clk), .rst_l(rst_l), .chk_en(chk_en), .fatal_en(fatal_en), .clr(clr),
        .cpx_vld(cpx_vld), .cpx_rtntype(cpx_rtntype), .cpx_nc(cpx_nc), .cpx_wv(cpx_wv),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_mask(rec_mask),
        .rec_cycle(rec_cycle), .viol_cnt(viol_cnt), .err_sticky(err_sticky),
        .fatal(fatal), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: records as a queue, counters as plain integers.
    typedef struct { logic [7:0] mask; logic [31:0] cyc; } mrec_t;
    mrec_t       mq[$];
    int          m_cnt[NCH];
    bit          m_err, m_ovf, m_fatal, m_trip;
    logic [31:0] m_cyc;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mq.delete();
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_err = 0; m_ovf = 0; m_fatal = 0; m_trip = 0; m_cyc = 0;
        end else begin : step
            logic [7:0] vm;
            bit         was_full, popd, drop;
            vm = '0;
            for (int i = 0; i < NCH; i++)
                if (chk_en && m_cyc >= GRACE && cpx_vld[i] && cpx_rtntype[4*i +: 4] == 4'h0
                    && cpx_nc[i] && cpx_wv[i]) vm[i] = 1'b1;
            was_full = (mq.size() == DEPTH);
            popd     = (mq.size() > 0) && rec_ready;
            drop     = 0;
            if (popd) void'(mq.pop_front());
            if (vm != 0) begin
                if (was_full && !popd) drop = 1;
                else mq.push_back('{vm, m_cyc});
            end
            m_fatal = !clr && !m_trip && (vm != 0) && fatal_en;
            m_trip  = clr ? 0 : (m_trip | m_fatal);
            for (int i = 0; i < NCH; i++) begin
                if (clr) m_cnt[i] = 0;
                else if (vm[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            end
            m_err = clr ? 0 : (m_err | (vm != 0));
            m_ovf = clr ? 0 : (m_ovf | drop);
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [63:0] ec;
        for (int i = 0; i < NCH; i++) ec[8*i +: 8] = 8'(m_cnt[i]);
        chk("m_rec_valid", rec_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("m_rec_mask", rec_mask, mq[0].mask);
            chk("m_rec_cycle", rec_cycle, mq[0].cyc);
        end
        chk("m_viol_cnt", viol_cnt, ec);
        chk("m_err_sticky", err_sticky, m_err);
        chk("m_fatal", fatal, m_fatal);
        chk("m_ovf", ovf, m_ovf);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_viol(input logic [7:0] m);
        cpx_vld     = m;
        cpx_nc      = m;
        cpx_wv      = m;
        cpx_rtntype = '0;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 1000 && m_cyc < n; k++) tick();
    endtask

    task automatic drain();
        rec_ready = 1'b1;
        for (int k = 0; k < 16 && rec_valid; k++) tick();
        rec_ready = 1'b0;
        chk("drain_empty", rec_valid, 0);
    endtask

    initial begin : stim
        logic [31:0] c0;
        int          n;
        rst_l = 1'b0; chk_en = 1'b1; fatal_en = 1'b0; clr = 1'b0; rec_ready = 1'b0;
        set_viol(8'h00);
        repeat (3) tick();
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        chk("rst_rec_mask", rec_mask, 0);
        chk("rst_rec_cycle", rec_cycle, 0);
        rst_l = 1'b1;

        // Violation inside the grace window is ignored.
        wait_cyc(5);
        set_viol(8'h04); tick(); set_viol(8'h00);
        chk("grace_cnt", viol_cnt, 0);
        chk("grace_rec", rec_valid, 0);

        // Each missing qualifier suppresses detection.
        wait_cyc(16);
        chk_en = 1'b0; set_viol(8'hFF); tick(); chk_en = 1'b1;
        set_viol(8'hFF); cpx_rtntype = {8{4'h1}}; tick();
        set_viol(8'hFF); cpx_nc = 8'h00; tick();
        set_viol(8'hFF); cpx_wv = 8'h00; tick();
        set_viol(8'h00);
        chk("neg_cnt", viol_cnt, 0);
        chk("neg_err", err_sticky, 0);
        chk("neg_rec", rec_valid, 0);

        wait_cyc(20);
        set_viol(8'h04); tick(); set_viol(8'h00);
        chk("c20_cnt", viol_cnt, 64'h0000_0000_0001_0000);
        chk("c20_err", err_sticky, 1);
        chk("c20_valid", rec_valid, 1);
        chk("c20_mask", rec_mask, 8'h04);
        chk("c20_cycle", rec_cycle, 32'd20);
        drain();

        // Fatal trip on a two-channel violation, no re-pulse, clr re-arms.
        fatal_en = 1'b1;
        set_viol(8'h81); tick(); set_viol(8'h00);
        chk("trip_fatal", fatal, 1);
        chk("trip_mask", rec_mask, 8'h81);
        tick();
        chk("trip_fatal_pulse", fatal, 0);
        set_viol(8'h01); tick(); set_viol(8'h00);
        chk("trip_no_refatal", fatal, 0);
        chk("trip_cnt0", viol_cnt[7:0], 8'd2);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_cnt", viol_cnt, 0);
        chk("clr_err", err_sticky, 0);
        set_viol(8'h01); tick(); set_viol(8'h00);
        chk("rearm_fatal", fatal, 1);
        fatal_en = 1'b0;
        drain();

        // Overflow: six violating cycles into a four-entry FIFO.
        clr = 1'b1; tick(); clr = 1'b0;
        c0 = m_cyc;
        repeat (6) begin set_viol(8'h08); tick(); end
        set_viol(8'h00);
        chk("ovf_set", ovf, 1);
        chk("ovf_cnt3", viol_cnt[31:24], 8'd6);
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_order_valid", rec_valid, 1);
            chk("ovf_order_cycle", rec_cycle, c0 + 32'(k));
            tick();
        end
        rec_ready = 1'b0;
        chk("ovf_drained", rec_valid, 0);

        // Full with simultaneous push and pop: nothing dropped.
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        c0 = m_cyc;
        repeat (4) begin set_viol(8'h08); tick(); end
        set_viol(8'h08); rec_ready = 1'b1; tick();
        set_viol(8'h00); rec_ready = 1'b0;
        chk("full_pp_ovf", ovf, 0);
        chk("full_pp_head", rec_cycle, c0 + 32'd1);
        n = 0;
        rec_ready = 1'b1;
        while (rec_valid && n < 10) begin n++; tick(); end
        rec_ready = 1'b0;
        chk("full_pp_occ", n, 4);

        // Saturation, then clr in a violating cycle.
        clr = 1'b1; tick(); clr = 1'b0;
        rec_ready = 1'b1;
        repeat (300) begin set_viol(8'h02); tick(); end
        set_viol(8'h00); tick();
        rec_ready = 1'b0;
        chk("sat_cnt", viol_cnt, 64'h0000_0000_0000_FF00);
        chk("sat_empty", rec_valid, 0);
        clr = 1'b1; set_viol(8'h02); c0 = m_cyc; tick();
        clr = 1'b0; set_viol(8'h00);
        chk("clrv_cnt", viol_cnt, 0);
        chk("clrv_err", err_sticky, 0);
        chk("clrv_valid", rec_valid, 1);
        chk("clrv_mask", rec_mask, 8'h02);
        chk("clrv_cycle", rec_cycle, c0);

        // Reset asserted mid-drain clears outputs without a clock edge.
        set_viol(8'h10); tick(); tick(); set_viol(8'h00);
        rec_ready = 1'b1; tick();
        #2 rst_l = 1'b0;
        #1;
        chk("mid_rst_valid", rec_valid, 0);
        chk("mid_rst_cnt", viol_cnt, 0);
        chk("mid_rst_err", err_sticky, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_mask", rec_mask, 0);
        rec_ready = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
